// File: rtl/my9262_pkg.sv
// Shared constants for the MY9262 frame sequencer: register map, bit positions, FSM states.
package my9262_pkg;

   localparam int IDX_W = 4;

   localparam logic [4:0] ADDR_CTRL   = 5'h10;
   localparam logic [4:0] ADDR_STATUS = 5'h11;
   localparam logic [4:0] ADDR_FCNT   = 5'h12;

   localparam int CTRL_GO     = 0;
   localparam int CTRL_AUTO   = 1;
   localparam int STAT_BUSY   = 0;
   localparam int STAT_FDONE  = 1;
   localparam int STAT_WRERR  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      NEXT  = 2'd3
   } my9262_state_e;

endpackage

// File: rtl/my9262_gray_buf.sv
// Grayscale register file: one synchronous write port, two asynchronous read ports.
module my9262_gray_buf
   import my9262_pkg::*;
#(
   parameter int CHANNELS = 16,
   parameter int DATA_W   = 16
)(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [IDX_W-1:0]  i_seq_addr,
   output logic [DATA_W-1:0] o_seq_data,
   input  logic [IDX_W-1:0]  i_avs_addr,
   output logic [DATA_W-1:0] o_avs_data
);

   localparam logic [IDX_W:0] N_CH = CHANNELS[IDX_W:0];

   logic [DATA_W-1:0] r_mem [CHANNELS];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < CHANNELS; i++) r_mem[i] <= '0;
      end else if (i_we && ({1'b0, i_waddr} < N_CH)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Addresses past the last channel read as zero.
   assign o_seq_data = ({1'b0, i_seq_addr} < N_CH) ? r_mem[i_seq_addr] : '0;
   assign o_avs_data = ({1'b0, i_avs_addr} < N_CH) ? r_mem[i_avs_addr] : '0;

endmodule

// File: rtl/my9262_frame_seq.sv
// Avalon-MM frame sequencer: streams the grayscale buffer, highest channel first, to a shift stage.
module my9262_frame_seq
   import my9262_pkg::*;
#(
   parameter int CHANNELS = 16,
   parameter int DATA_W   = 16
)(
   input  logic              csi_clk,
   input  logic              rsi_reset_n,
   input  logic [4:0]        avs_address,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic              avs_read,
   output logic [31:0]       avs_readdata,
   output logic [DATA_W-1:0] my9262_Data,
   output logic              my9262_Start,
   output logic              my9262_Last,
   input  logic              my9262_Done,
   output my9262_state_e     o_dbg_state
);

   localparam logic [IDX_W:0]   N_CH  = CHANNELS[IDX_W:0];
   localparam logic [IDX_W-1:0] CH_M1 = N_CH[IDX_W-1:0] - 1'b1;

   my9262_state_e     r_state, w_next_state;
   logic [IDX_W-1:0]  r_idx, w_next_idx;
   logic [DATA_W-1:0] r_data;
   logic              r_last, r_auto, r_fdone, r_wrerr;
   logic [15:0]       r_fcnt;
   logic [31:0]       r_readdata, w_rd_mux;
   logic [DATA_W-1:0] w_seq_rd, w_avs_rd;
   logic              w_busy, w_buf_wsel, w_ctrl_wr, w_stat_wr, w_go, w_frame_end;
   logic              w_unused;

   assign w_busy     = (r_state != IDLE);
   assign w_buf_wsel = avs_write && !avs_address[4] && ({1'b0, avs_address[3:0]} < N_CH);
   assign w_ctrl_wr  = avs_write && (avs_address == ADDR_CTRL);
   assign w_stat_wr  = avs_write && (avs_address == ADDR_STATUS);
   assign w_go       = w_ctrl_wr && avs_writedata[CTRL_GO];
   assign w_unused   = &{1'b0, avs_writedata[31:3]};

   my9262_gray_buf #(.CHANNELS(CHANNELS), .DATA_W(DATA_W)) u_buf (
      .i_clk      (csi_clk),
      .i_rst_n    (rsi_reset_n),
      .i_we       (w_buf_wsel && !w_busy),
      .i_waddr    (avs_address[3:0]),
      .i_wdata    (avs_writedata[DATA_W-1:0]),
      .i_seq_addr (w_next_idx),
      .o_seq_data (w_seq_rd),
      .i_avs_addr (avs_address[3:0]),
      .o_avs_data (w_avs_rd)
   );

   always_comb begin
      w_next_state = r_state;
      w_next_idx   = r_idx;
      w_frame_end  = 1'b0;
      case (r_state)
         IDLE: if (w_go) begin
            w_next_state = ISSUE;
            w_next_idx   = CH_M1;
         end
         ISSUE: w_next_state = WAIT;
         WAIT:  if (my9262_Done) w_next_state = NEXT;
         NEXT: begin
            if (r_idx != '0) begin
               w_next_idx   = r_idx - 1'b1;
               w_next_state = ISSUE;
            end else begin
               w_frame_end = 1'b1;
               if (r_auto) begin
                  w_next_idx   = CH_M1;
                  w_next_state = ISSUE;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_rd_mux = '0;
      if (!avs_address[4]) begin
         w_rd_mux = 32'(w_avs_rd);
      end else begin
         case (avs_address)
            ADDR_CTRL:   w_rd_mux[CTRL_AUTO] = r_auto;
            ADDR_STATUS: begin
               w_rd_mux[STAT_BUSY]  = w_busy;
               w_rd_mux[STAT_FDONE] = r_fdone;
               w_rd_mux[STAT_WRERR] = r_wrerr;
            end
            ADDR_FCNT:   w_rd_mux[15:0] = r_fcnt;
            default:     w_rd_mux = '0;
         endcase
      end
   end

   always_ff @(posedge csi_clk) begin
      if (!rsi_reset_n) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_data     <= '0;
         r_last     <= 1'b0;
         r_auto     <= 1'b0;
         r_fdone    <= 1'b0;
         r_wrerr    <= 1'b0;
         r_fcnt     <= '0;
         r_readdata <= '0;
      end else begin
         r_state <= w_next_state;
         r_idx   <= w_next_idx;
         // Word is latched on entry to ISSUE so it is already valid while Start is high.
         if (w_next_state == ISSUE) begin
            r_data <= w_seq_rd;
            r_last <= (w_next_idx == '0);
         end
         if (w_ctrl_wr) r_auto <= avs_writedata[CTRL_AUTO];
         if (w_frame_end) r_fdone <= 1'b1;
         else if (w_stat_wr && avs_writedata[STAT_FDONE]) r_fdone <= 1'b0;
         if (w_buf_wsel && w_busy) r_wrerr <= 1'b1;
         else if (w_stat_wr && avs_writedata[STAT_WRERR]) r_wrerr <= 1'b0;
         if (w_frame_end) r_fcnt <= r_fcnt + 1'b1;
         if (avs_read) r_readdata <= w_rd_mux;
      end
   end

   assign avs_readdata = r_readdata;
   assign my9262_Data  = r_data;
   assign my9262_Last  = r_last;
   assign my9262_Start = (r_state == ISSUE);
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_my9262_frame_seq.sv
// Directed bench for my9262_frame_seq: register table plus multi-cycle frame sequences.
`timescale 1ns/1ps
module tb_my9262_frame_seq;
   import my9262_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [4:0]    avs_address = '0;
   logic          avs_write = 1'b0;
   logic [31:0]   avs_writedata = '0;
   logic          avs_read = 1'b0;
   logic [31:0]   avs_readdata;
   logic [15:0]   data;
   logic          start, last;
   logic          done = 1'b0;
   my9262_state_e dbg_state;

   int checks = 0, failures = 0, cyc = 0, n_starts = 0, cd = 0, last_done_cyc = 0;
   bit resp_en = 1'b1, auto_done = 1'b0, spacing_arm = 1'b0, in_word = 1'b0;
   logic [16:0] exp_q[$];
   logic [16:0] cur_exp = '0;
   logic [31:0] rd;
   int s0;

   my9262_frame_seq #(.CHANNELS(16), .DATA_W(16)) dut (
      .csi_clk       (clk),
      .rsi_reset_n   (rst_n),
      .avs_address   (avs_address),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_read      (avs_read),
      .avs_readdata  (avs_readdata),
      .my9262_Data   (data),
      .my9262_Start  (start),
      .my9262_Last   (last),
      .my9262_Done   (done),
      .o_dbg_state   (dbg_state)
   );

   // clock / cycle counter / watchdog
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Done as seen by the DUT at the clock edge.
   always @(posedge clk) begin
      if (rst_n && done) begin
         last_done_cyc = cyc;
         spacing_arm   = 1'b1;
         in_word       = 1'b0;
      end
   end

   // Downstream model and scoreboard: pops expected words on Start, answers with Done 3 cycles later.
   always @(negedge clk) begin
      if (!rst_n) begin
         cd = 0; spacing_arm = 1'b0; in_word = 1'b0;
         if (auto_done) begin done = 1'b0; auto_done = 1'b0; end
      end else begin
         if (auto_done) begin done = 1'b0; auto_done = 1'b0; end
         if (resp_en && cd > 0) begin
            cd--;
            if (cd == 0) begin done = 1'b1; auto_done = 1'b1; end
         end
         if (start) begin
            n_starts++;
            if (spacing_arm) check("done_to_start", cyc - last_done_cyc, 2);
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_start: got data 0x%0h with no word expected", data);
            end else begin
               cur_exp = exp_q.pop_front();
               check("start_word", {15'd0, last, data}, {15'd0, cur_exp});
            end
            in_word = 1'b1;
            if (resp_en) cd = 3;
         end else if (in_word) begin
            check("word_stable", {15'd0, last, data}, {15'd0, cur_exp});
         end
      end
   end

   // driver tasks (all run in the posedge+1 phase)
   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic avs_wr(input logic [4:0] a, input logic [31:0] d);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      tick(1);
      avs_write = 1'b0;
   endtask

   task automatic avs_rd(input logic [4:0] a, output logic [31:0] d);
      avs_address = a; avs_read = 1'b1;
      tick(1);
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   task automatic avs_go(input logic [31:0] v);
      spacing_arm = 1'b0;
      avs_wr(ADDR_CTRL, v);
   endtask

   task automatic load_buf();
      for (int i = 0; i < 16; i++) avs_wr(5'(i), 32'h1000 + 32'(i));
   endtask

   task automatic push_frame();
      for (int i = 15; i >= 0; i--) exp_q.push_back({1'(i == 0), 16'h1000 + 16'(i)});
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (dbg_state != IDLE && k < budget) begin tick(1); k++; end
      check("idle_reached", 32'(dbg_state == IDLE), 1);
   endtask

   task automatic wait_starts(input int target, input int budget);
      int k = 0;
      while (n_starts < target && k < budget) begin tick(1); k++; end
      check("start_count_reached", 32'(n_starts >= target), 1);
   endtask

   task automatic wait_start_pulse(input int budget);
      int k = 0;
      while (!start && k < budget) begin tick(1); k++; end
      check("start_pulse_seen", 32'(start), 1);
   endtask

   typedef struct {
      bit          wr;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
      string       name;
   } vec_t;
   vec_t vt[16];

   initial begin
      vt[0]  = '{1'b0, 5'h10, 32'h0,        32'h0,    "rst_ctrl"};
      vt[1]  = '{1'b0, 5'h11, 32'h0,        32'h0,    "rst_status"};
      vt[2]  = '{1'b0, 5'h12, 32'h0,        32'h0,    "rst_fcnt"};
      vt[3]  = '{1'b0, 5'h03, 32'h0,        32'h0,    "rst_buf3"};
      vt[4]  = '{1'b1, 5'h03, 32'hFFFFABCD, 32'h0,    "wr_buf3"};
      vt[5]  = '{1'b0, 5'h03, 32'h0,        32'hABCD, "buf3_low16"};
      vt[6]  = '{1'b0, 5'h13, 32'h0,        32'h0,    "unmapped_13"};
      vt[7]  = '{1'b0, 5'h1F, 32'h0,        32'h0,    "unmapped_1f"};
      vt[8]  = '{1'b1, 5'h10, 32'h2,        32'h0,    "wr_auto"};
      vt[9]  = '{1'b0, 5'h10, 32'h0,        32'h2,    "ctrl_auto_rb"};
      vt[10] = '{1'b1, 5'h10, 32'h0,        32'h0,    "wr_ctrl0"};
      vt[11] = '{1'b0, 5'h10, 32'h0,        32'h0,    "ctrl_zero_rb"};
      vt[12] = '{1'b1, 5'h11, 32'h7,        32'h0,    "wr_status"};
      vt[13] = '{1'b0, 5'h11, 32'h0,        32'h0,    "status_ro"};
      vt[14] = '{1'b1, 5'h0F, 32'h5A5A,     32'h0,    "wr_buf15"};
      vt[15] = '{1'b0, 5'h0F, 32'h0,        32'h5A5A, "buf15_rb"};

      // reset
      tick(3);
      check("rst_start", 32'(start), 0);
      check("rst_data", 32'(data), 0);
      check("rst_last", 32'(last), 0);
      check("rst_readdata", avs_readdata, 0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      rst_n = 1'b1;
      tick(1);

      // register table
      for (int i = 0; i < 16; i++) begin
         if (vt[i].wr) avs_wr(vt[i].addr, vt[i].data);
         else begin
            avs_rd(vt[i].addr, rd);
            check(vt[i].name, rd, vt[i].exp);
         end
      end

      // single frame, Done 3 cycles after each Start
      load_buf();
      push_frame();
      s0 = n_starts;
      avs_go(32'h1);
      wait_idle(500);
      check("f1_starts", n_starts - s0, 16);
      check("f1_queue_empty", exp_q.size(), 0);
      avs_rd(ADDR_STATUS, rd); check("f1_status", rd, 32'h2);
      avs_rd(ADDR_FCNT, rd);   check("f1_fcnt", rd, 1);

      // Done in IDLE, GO twice mid-frame, grayscale write while busy
      avs_wr(ADDR_STATUS, 32'h2);
      s0 = n_starts;
      done = 1'b1; tick(1); done = 1'b0; tick(3);
      check("idle_done_state", 32'(dbg_state), 32'(IDLE));
      check("idle_done_starts", n_starts - s0, 0);
      push_frame();
      avs_go(32'h1);
      wait_starts(s0 + 4, 200);
      avs_wr(ADDR_CTRL, 32'h1);
      wait_starts(s0 + 10, 200);
      avs_wr(ADDR_CTRL, 32'h1);
      avs_wr(5'h05, 32'hBEEF);
      wait_idle(500);
      tick(10);
      check("go_busy_starts", n_starts - s0, 16);
      avs_rd(5'h05, rd);       check("buf5_kept", rd, 32'h1005);
      avs_rd(ADDR_STATUS, rd); check("wrerr_set", rd, 32'h6);
      avs_wr(ADDR_STATUS, 32'h4);
      avs_rd(ADDR_STATUS, rd); check("wrerr_clr", rd, 32'h2);
      avs_rd(ADDR_FCNT, rd);   check("f2_fcnt", rd, 2);

      // AUTO: two full frames, AUTO cleared during the third (counter continues from 2)
      s0 = n_starts;
      repeat (3) push_frame();
      avs_go(32'h3);
      wait_starts(s0 + 35, 800);
      avs_wr(ADDR_CTRL, 32'h0);
      wait_idle(500);
      tick(20);
      check("auto_starts", n_starts - s0, 48);
      check("auto_state", 32'(dbg_state), 32'(IDLE));
      avs_rd(ADDR_FCNT, rd);   check("auto_fcnt", rd, 5);
      avs_rd(ADDR_CTRL, rd);   check("auto_cleared", rd, 0);

      // FRAME_DONE clear in the same cycle as the end-of-frame set: set wins
      avs_wr(ADDR_STATUS, 32'h2);
      avs_rd(ADDR_STATUS, rd); check("fdone_pre_clr", rd, 0);
      resp_en = 1'b0;
      push_frame();
      avs_go(32'h1);
      for (int w = 0; w < 16; w++) begin
         wait_start_pulse(50);
         tick(2);
         done = 1'b1; tick(1); done = 1'b0;
         if (w == 15) avs_wr(ADDR_STATUS, 32'h2);
      end
      resp_en = 1'b1;
      wait_idle(50);
      avs_rd(ADDR_STATUS, rd); check("fdone_set_wins", rd, 32'h2);
      avs_rd(ADDR_FCNT, rd);   check("f6_fcnt", rd, 6);

      // reset during WAIT of word 0x1007 aborts the frame
      push_frame();
      s0 = n_starts;
      avs_go(32'h3);
      wait_starts(s0 + 9, 200);
      check("pre_rst_state", 32'(dbg_state), 32'(WAIT));
      rst_n = 1'b0; tick(1); rst_n = 1'b1;
      exp_q.delete();
      s0 = n_starts;
      check("post_rst_data", 32'(data), 0);
      check("post_rst_last", 32'(last), 0);
      tick(30);
      check("post_rst_no_start", n_starts - s0, 0);
      avs_rd(ADDR_CTRL, rd);   check("post_rst_ctrl", rd, 0);
      avs_rd(ADDR_STATUS, rd); check("post_rst_status", rd, 0);
      avs_rd(ADDR_FCNT, rd);   check("post_rst_fcnt", rd, 0);
      avs_rd(5'h00, rd);       check("post_rst_buf0", rd, 0);
      avs_rd(5'h0F, rd);       check("post_rst_buf15", rd, 0);
      load_buf();
      push_frame();
      s0 = n_starts;
      avs_go(32'h1);
      wait_idle(500);
      check("restart_starts", n_starts - s0, 16);
      avs_rd(ADDR_FCNT, rd);   check("restart_fcnt", rd, 1);

      // FRAME_CNT wrap from 0xFFFF
      force dut.r_fcnt = 16'hFFFF;
      tick(1);
      release dut.r_fcnt;
      avs_rd(ADDR_FCNT, rd);   check("fcnt_preset", rd, 32'hFFFF);
      push_frame();
      avs_go(32'h1);
      wait_idle(500);
      avs_rd(ADDR_FCNT, rd);   check("fcnt_wrap", rd, 0);

      check("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/my9262_frame_seq.md
MY9262_FRAME_SEQ -- requirements
Module: my9262_frame_seq

Interface
REQ-001 Parameter CHANNELS, default 16, number of 16-bit grayscale words per frame (legal 1..16).
REQ-002 Parameter DATA_W, default 16, width of each grayscale word.
REQ-003 csi_clk  input  1  system clock; the only clock.
REQ-004 rsi_reset_n  input  1  reset; synchronous, active-low.
REQ-005 avs_address  input  5  Avalon-MM word address.
REQ-006 avs_write  input  1  Avalon-MM write request.
REQ-007 avs_writedata  input  32  Avalon-MM write data.
REQ-008 avs_read  input  1  Avalon-MM read request.
REQ-009 avs_readdata  output  32  Avalon-MM read data.
REQ-010 my9262_Data  output  DATA_W  word presented to the downstream shift stage.
REQ-011 my9262_Start  output  1  one-cycle pulse; the downstream stage starts shifting my9262_Data.
REQ-012 my9262_Last  output  1  high with my9262_Data when the word is the final word of the frame.
REQ-013 my9262_Done  input  1  one-cycle pulse from the downstream stage when the current word has been shifted out.

Function
REQ-014 Register map:
- 0x00..0x0F: grayscale buffer, writedata[15:0]; only addresses below CHANNELS are writable and readable.
- 0x10: CTRL. bit0 GO is write-1 self-clearing; bit1 AUTO is read/write.
- 0x11: STATUS, read-only. bit0 BUSY; bit1 FRAME_DONE is sticky and cleared by a write of 1; bit2 WR_ERR is sticky and cleared by a write of 1.
- 0x12: FRAME_CNT[15:0], read-only.
REQ-015 Reads shall have fixed latency 1: avs_readdata is registered and valid on the cycle after avs_read. Unmapped addresses shall read 0.
REQ-016 The FSM shall have the states IDLE, ISSUE, WAIT and NEXT.
REQ-017 IDLE -> ISSUE on a GO write; the channel index idx is loaded with CHANNELS-1.
REQ-018 In ISSUE:
- my9262_Data = buf[idx].
- my9262_Last = (idx==0).
- my9262_Start pulses for exactly 1 cycle.
- Go to WAIT.
REQ-019 In WAIT, my9262_Data and my9262_Last shall hold stable. Go to NEXT on my9262_Done.
REQ-020 In NEXT:
- If idx!=0: decrement idx and go to ISSUE.
- Otherwise: set FRAME_DONE, increment FRAME_CNT (wraps 0xFFFF -> 0), and go to ISSUE with idx=CHANNELS-1 if AUTO=1, else go to IDLE.
REQ-021 Start-to-start spacing: minimum 2 cycles after Done, i.e. Done in cycle n gives the next Start in cycle n+2.
REQ-022 BUSY = (state != IDLE).
REQ-023 GO while BUSY shall be ignored, with no error.
REQ-024 my9262_Done outside WAIT shall be ignored.
REQ-025 Grayscale writes while BUSY shall be dropped (buffer unchanged) and shall set WR_ERR. CTRL/STATUS writes shall always be accepted.
REQ-026 Clearing AUTO mid-frame shall let the current frame complete and then return to IDLE.
REQ-027 A FRAME_DONE clear and a FRAME_DONE set in the same cycle: set wins.
REQ-028 Frame word order shall be buf[CHANNELS-1] first and buf[0] last (daisy-chain order).

Reset
REQ-029 While rsi_reset_n=0 at a csi_clk edge:
- state=IDLE, idx=0.
- my9262_Data=0, my9262_Start=0, my9262_Last=0, avs_readdata=0.
- AUTO=0, FRAME_DONE=0, WR_ERR=0, FRAME_CNT=0.
- Buffer contents shall be cleared to 0.
REQ-030 Reset asserted mid-frame shall abort with no further Start pulses. The downstream stage is reset by the same signal.

Structure
REQ-031 A shared package my9262_pkg shall hold:
- register address constants (ADDR_CTRL=0x10, ADDR_STATUS=0x11, ADDR_FCNT=0x12);
- CTRL/STATUS bit positions;
- the FSM state enum.
REQ-032 The block shall contain one sub-module, my9262_gray_buf: a CHANNELS x DATA_W register file with one write port and two asynchronous read ports (sequencer read and Avalon read).

Verification
REQ-033 Write buf[i]=0x1000+i for i=0..15, write CTRL=0x1, and answer each Start with Done 3 cycles later -> 16 Starts with Data 0x100F..0x1000 descending; Last only on 0x1000; FRAME_DONE=1; FRAME_CNT=1; BUSY=0.
REQ-034 Write CTRL=0x3 (AUTO), run 2 frames, then write CTRL=0x0 during the third frame -> exactly 48 Starts, FRAME_CNT=3, then IDLE.
REQ-035 Write buf[5]=0xBEEF while BUSY -> buf[5] reads back its old value; STATUS.WR_ERR=1; writing STATUS=0x4 clears it.
REQ-036 Pulse Done in IDLE, and GO twice mid-frame -> no extra Start; word count per frame stays 16.
REQ-037 Assert reset for 1 cycle during WAIT of word 7 -> no Start afterward; all registers read 0; a new GO restarts from 0x100F... (buffer reloaded).
REQ-038 FRAME_CNT preset via 65535 frames (or forced) -> the next frame wraps it to 0x0000.
